bcd_multidigit_counter: RTL and testbench
=========================================

// Module: bcd_multidigit_counter
// PURPOSE
//  Parametrised N-digit cascaded modulo/BCD counter, successor to the single-digit counter.
//  - Counts up or down.
//  - Supports synchronous clear and parallel load.
//  - Wrap or saturate at terminal count.
//  - Provides a per-digit carry vector for downstream dividers and UART/txd bit/baud timing.
//  - Sits in the txd/rxd timing datapath and in the seven-segment/statistics counters.
// PARAMETERS
//  NUM_DIGITS    4   number of cascaded digits (1..8)
//  COUNT_CEILING 10  modulus of every digit (2..16); each digit counts 0..COUNT_CEILING-1
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               asynchronous, active-low reset (0 = reset)
//  enb          in   1               count enable for the least-significant digit
//  up           in   1               1 = count up, 0 = count down
//  clr          in   1               synchronous clear to all-zero
//  load         in   1               synchronous parallel load of load_val
//  load_val     in   4*NUM_DIGITS    load value, digit i at [4i+3:4i]
//  wrap_en      in   1               1 = wrap at terminal count, 0 = saturate
//  Q            out  4*NUM_DIGITS    registered count, digit i at [4i+3:4i]
//  digit_carry  out  NUM_DIGITS      combinational carry/borrow out of each digit
//  carry        out  1               combinational terminal event (= digit_carry[NUM_DIGITS-1])
//  at_term      out  1               combinational: Q is at terminal value for the current direction
// BEHAVIOUR
//  - Reset (reset==0, async): every digit of Q = 0; no other state exists.
//    - Combinational outputs follow from Q=0 (at_term=1 when up==0).
//  - Priority each clock edge: clr > load > enb.
//    - clr: Q <= 0.
//    - load: Q <= load_val, with any digit >= COUNT_CEILING clamped to COUNT_CEILING-1.
//    - enb: count.
//    - none of these: hold.
//  - Terminal digit value T = COUNT_CEILING-1 when up, 0 when down.
//  - Digit 0 enable e0 = enb & ~clr & ~load.
//  - Digit i>0 enable e(i) = digit_carry[i-1].
//  - digit_carry[i] = e(i) & (digit i == T).
//    - Purely combinational ripple, like the single-digit carry.
//    - Never asserted while clr or load is high.
//  - Enabled digit:
//    - up: at T -> 0, else +1.
//    - down: at T -> COUNT_CEILING-1, else -1.
//  - at_term = all digits == T (independent of enb).
//  - Saturate (wrap_en==0): when carry would be 1, Q holds entirely instead of rolling.
//    - carry is still asserted for that cycle so overflow is observable.
//    - Lower digits do not roll either.
//  - Wrap (wrap_en==1):
//    - up from all-T rolls to all-0.
//    - down from all-0 rolls to all COUNT_CEILING-1.
//    - carry pulses for exactly that enabled cycle.
//  - Latency: Q changes on the edge after the qualifying inputs; carry is same-cycle, zero latency.
//  - Changing up mid-count takes effect the same cycle: carry/at_term are re-evaluated combinationally.
//  - Reset asserted mid-count clears Q immediately, without waiting for a clock edge.
//    - Counting resumes on the first edge after reset deasserts.
//  - Digit values >= COUNT_CEILING are unreachable except via load, which clamps.
// STRUCTURE
//  - Package bcd_pkg: typedef logic [3:0] digit_t; function clamp_digit(digit_t, ceiling).
//  - Sub-module bcd_digit_updn: one digit with ports clk, reset, en, up, clr, load, ld_val, wrap_en, q, cout.
//    - Instantiated NUM_DIGITS times in a generate loop.
//    - The top-level cell holds the carry ripple, the saturate hold qualifier and the at_term reduction.
// TESTING
//  - Reset: drive reset=0 mid-count (Q=16'h0473) -> Q=16'h0000 before the next edge.
//    - Hold reset low 3 cycles -> Q stays 0.
//  - Up wrap: load 16'h9998, up=1, wrap_en=1, enb=1 for 3 cycles.
//    - Q = 9999, then 0000, then 0001.
//    - carry=1 only in the cycle Q==9999.
//  - Down/borrow: load 16'h1000, up=0, enb=1.
//    - Q=0999, digit_carry=4'b0111 on that edge.
//    - From 0000 with wrap_en=1 -> 9999 with carry=1.
//  - Saturate: Q=9999, up=1, wrap_en=0, enb=1 for 5 cycles.
//    - Q stays 9999; carry=1 each enabled cycle; at_term=1.
//  - Priority/clamp: clr=1, load=1, enb=1 same edge -> Q=0000.
//    - load=1 with load_val=16'hFA35 -> Q=16'h9935; digit_carry=0 while load=1.
//  - Parameter sweep: NUM_DIGITS=2, COUNT_CEILING=6, 40 enables up from 00.
//    - Q=14 (base-6 digits 1,4) after 10 enables.
//    - carry once at enable 36; Q=04 after 40 enables.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the cascaded BCD/modulo counter.
package bcd_pkg;

  typedef logic [3:0] digit_t;

  // Loaded digits at or above the modulus are pulled back to the largest legal value.
  function automatic digit_t clamp_digit(input digit_t d, input int unsigned ceiling);
    if ({28'd0, d} >= ceiling) return digit_t'(ceiling - 1);
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_updn.sv
// One up/down modulo digit; cout is the combinational carry/borrow out of this digit.
module bcd_digit_updn
  import bcd_pkg::*;
#(
  parameter int unsigned COUNT_CEILING = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   up,
  input  logic   clr,
  input  logic   load,
  input  digit_t ld_val,
  input  logic   wrap_en,
  output digit_t q,
  output logic   cout
);

  localparam digit_t MAX_VAL = digit_t'(COUNT_CEILING - 1);

  digit_t term;

  assign term = up ? MAX_VAL : '0;
  assign cout = en & (q == term);

  // wrap_en here means "allowed to roll over"; the top withholds it while saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= clamp_digit(ld_val, COUNT_CEILING);
    end else if (en) begin
      if (q == term) begin
        if (wrap_en) q <= up ? '0 : MAX_VAL;
      end else begin
        q <= up ? q + 4'd1 : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_multidigit_counter.sv
// N-digit cascaded up/down modulo counter with clear, load, wrap/saturate and per-digit carries.
module bcd_multidigit_counter
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned COUNT_CEILING = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enb,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    wrap_en,
  output logic [4*NUM_DIGITS-1:0] Q,
  output logic [NUM_DIGITS-1:0]   digit_carry,
  output logic                    carry,
  output logic                    at_term
);

  localparam digit_t MAX_VAL = digit_t'(COUNT_CEILING - 1);

  digit_t                term;
  logic [NUM_DIGITS-1:0] at_t;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  roll_ok;

  assign term = up ? MAX_VAL : '0;

  // Enable ripple is built from the registered digits only, so there is no loop through the cells.
  always_comb begin
    logic run;
    dig_en = '0;
    run    = enb & ~clr & ~load;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_en[i] = run;
      run       = run & at_t[i];
    end
  end

  assign carry   = digit_carry[NUM_DIGITS-1];
  assign at_term = &at_t;
  // A full terminal event while saturating freezes every digit; all of them sit at T then.
  assign roll_ok = wrap_en | ~carry;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign at_t[g] = (Q[4*g +: 4] == term);

    bcd_digit_updn #(
      .COUNT_CEILING(COUNT_CEILING)
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .en     (dig_en[g]),
      .up     (up),
      .clr    (clr),
      .load   (load),
      .ld_val (load_val[4*g +: 4]),
      .wrap_en(roll_ok),
      .q      (Q[4*g +: 4]),
      .cout   (digit_carry[g])
    );
  end

endmodule

// File: tb/tb_bcd_multidigit_counter.sv
// Randomised and directed bench for the cascaded counter against an integer-valued model.
module tb_bcd_multidigit_counter;

  logic        clk = 1'b0;
  logic        reset, enb, up, clr, load, wrap_en;
  logic [15:0] load_val;
  logic [7:0]  load_val6;
  logic [15:0] Q;
  logic [3:0]  digit_carry;
  logic        carry, at_term;
  logic [7:0]  Q6;
  logic [1:0]  dc6;
  logic        carry6, at_term6;

  int n_cmp = 0;
  int n_err = 0;
  int mv    = 0;
  int mv6   = 0;

  always #5 clk = ~clk;

  bcd_multidigit_counter #(.NUM_DIGITS(4), .COUNT_CEILING(10)) dut (
    .clk(clk), .reset(reset), .enb(enb), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .wrap_en(wrap_en), .Q(Q), .digit_carry(digit_carry),
    .carry(carry), .at_term(at_term)
  );

  bcd_multidigit_counter #(.NUM_DIGITS(2), .COUNT_CEILING(6)) dut6 (
    .clk(clk), .reset(reset), .enb(enb), .up(up), .clr(clr), .load(load),
    .load_val(load_val6), .wrap_en(wrap_en), .Q(Q6), .digit_carry(dc6),
    .carry(carry6), .at_term(at_term6)
  );

  // ---------------- reference model: counter value as a plain integer ----------------
  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= b;
    return r;
  endfunction

  function automatic int clampv(input logic [31:0] lv, input int m, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) begin
      int d;
      d = int'(lv[4*i +: 4]);
      if (d > m - 1) d = m - 1;
      s += d * ipow(m, i);
    end
    return s;
  endfunction

  function automatic logic [31:0] to_q(input int v, input int m, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[4*i +: 4] = 4'((v / ipow(m, i)) % m);
    return r;
  endfunction

  function automatic logic [7:0] exp_dc(input int v, input int m, input int n, input bit e0, input bit u);
    logic [7:0] r = '0;
    for (int i = 0; i < n; i++) begin
      int p;
      p = ipow(m, i + 1);
      r[i] = e0 && (u ? (v % p == p - 1) : (v % p == 0));
    end
    return r;
  endfunction

  function automatic bit exp_at(input int v, input int m, input int n, input bit u);
    return u ? (v == ipow(m, n) - 1) : (v == 0);
  endfunction

  function automatic int next_v(input int v, input int m, input int n, input bit e, input bit u,
                                input bit c, input bit l, input bit w, input logic [31:0] lv);
    int mx;
    mx = ipow(m, n) - 1;
    if (c) return 0;
    if (l) return clampv(lv, m, n);
    if (!e) return v;
    if (u) begin
      if (v == mx) return w ? 0 : v;
      return v + 1;
    end
    if (v == 0) return w ? mx : 0;
    return v - 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input bit e, input bit u, input bit c, input bit l, input logic [15:0] lv, input bit w);
    @(negedge clk);
    enb = e; up = u; clr = c; load = l; load_val = lv; load_val6 = lv[7:0]; wrap_en = w;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mv  = next_v(mv, 10, 4, enb, up, clr, load, wrap_en, {16'd0, load_val});
    mv6 = next_v(mv6, 6, 2, enb, up, clr, load, wrap_en, {24'd0, load_val6});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] eq;
    reset = 1'b0; enb = 0; up = 0; clr = 0; load = 0; load_val = '0; load_val6 = '0; wrap_en = 1;
    #2;
    n_cmp++; if (Q !== 16'h0000) begin n_err++; $display("FAIL reset_init Q: got %h want 0000", Q); end
    n_cmp++; if (at_term !== 1'b1) begin n_err++; $display("FAIL reset_init at_term: got %b want 1", at_term); end
    @(negedge clk); reset = 1'b1;
    apply(0, 1, 0, 1, 16'h0473, 1);
    tick();
    n_cmp++; if (Q !== 16'h0473) begin n_err++; $display("FAIL reset_load Q: got %h want 0473", Q); end
    apply(1, 1, 0, 0, 16'h0000, 1);
    #2 reset = 1'b0;
    #1;
    mv = 0; mv6 = 0;
    n_cmp++; if (Q !== 16'h0000) begin n_err++; $display("FAIL reset_async Q: got %h want 0000", Q); end
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++; if (Q !== 16'h0000) begin n_err++; $display("FAIL reset_hold Q: got %h want 0000", Q); end
    end
    @(negedge clk); reset = 1'b1;
    tick();
    eq = to_q(mv, 10, 4);
    n_cmp++; if (Q !== 16'h0001 || Q !== eq[15:0]) begin n_err++; $display("FAIL reset_resume Q: got %h want 0001", Q); end
  endtask

  task automatic test_up_wrap();
    logic [15:0] seq [3];
    logic [31:0] eq;
    logic [7:0]  edc;
    seq[0] = 16'h9999; seq[1] = 16'h0000; seq[2] = 16'h0001;
    apply(0, 1, 0, 1, 16'h9998, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 0, 0, 16'h0000, 1);
      edc = exp_dc(mv, 10, 4, 1'b1, 1'b1);
      n_cmp++; if (carry !== edc[3] || carry !== (k == 1)) begin n_err++; $display("FAIL up_wrap carry[%0d]: got %b want %b", k, carry, edc[3]); end
      tick();
      eq = to_q(mv, 10, 4);
      n_cmp++; if (Q !== seq[k] || Q !== eq[15:0]) begin n_err++; $display("FAIL up_wrap Q[%0d]: got %h want %h", k, Q, seq[k]); end
    end
  endtask

  task automatic test_down_borrow();
    logic [31:0] eq;
    logic [7:0]  edc;
    apply(0, 0, 0, 1, 16'h1000, 1);
    tick();
    apply(1, 0, 0, 0, 16'h0000, 1);
    edc = exp_dc(mv, 10, 4, 1'b1, 1'b0);
    n_cmp++; if (digit_carry !== 4'b0111 || digit_carry !== edc[3:0]) begin n_err++; $display("FAIL down_borrow digit_carry: got %b want 0111", digit_carry); end
    tick();
    n_cmp++; if (Q !== 16'h0999) begin n_err++; $display("FAIL down_borrow Q: got %h want 0999", Q); end
    apply(0, 0, 0, 1, 16'h0000, 1);
    tick();
    apply(1, 0, 0, 0, 16'h0000, 1);
    n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL down_wrap carry: got %b want 1", carry); end
    n_cmp++; if (at_term !== 1'b1) begin n_err++; $display("FAIL down_wrap at_term: got %b want 1", at_term); end
    tick();
    eq = to_q(mv, 10, 4);
    n_cmp++; if (Q !== 16'h9999 || Q !== eq[15:0]) begin n_err++; $display("FAIL down_wrap Q: got %h want 9999", Q); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      apply(1, 1, 0, 0, 16'h0000, 0);
      n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL saturate carry[%0d]: got %b want 1", k, carry); end
      n_cmp++; if (at_term !== 1'b1) begin n_err++; $display("FAIL saturate at_term[%0d]: got %b want 1", k, at_term); end
      tick();
      n_cmp++; if (Q !== 16'h9999 || mv != 9999) begin n_err++; $display("FAIL saturate Q[%0d]: got %h want 9999", k, Q); end
    end
  endtask

  task automatic test_priority_clamp();
    apply(1, 1, 1, 1, 16'h1234, 1);
    n_cmp++; if (digit_carry !== 4'b0000) begin n_err++; $display("FAIL prio_clr digit_carry: got %b want 0000", digit_carry); end
    tick();
    n_cmp++; if (Q !== 16'h0000) begin n_err++; $display("FAIL prio_clr Q: got %h want 0000", Q); end
    apply(1, 0, 0, 1, 16'hFA35, 1);
    n_cmp++; if (digit_carry !== 4'b0000) begin n_err++; $display("FAIL clamp digit_carry: got %b want 0000", digit_carry); end
    tick();
    n_cmp++; if (Q !== 16'h9935 || mv != 9935) begin n_err++; $display("FAIL clamp Q: got %h want 9935", Q); end
  endtask

  task automatic test_random();
    logic [31:0] eq;
    logic [7:0]  edc;
    logic [15:0] lv;
    bit e, u, c, l, w;
    for (int k = 0; k < 400; k++) begin
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1);
      c = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: lv = 16'h9997;
        1: lv = 16'h0002;
        default: lv = 16'($urandom);
      endcase
      apply(e, u, c, l, lv, w);
      edc = exp_dc(mv, 10, 4, e && !c && !l, u);
      n_cmp++; if (digit_carry !== edc[3:0]) begin n_err++; $display("FAIL rand digit_carry[%0d]: got %b want %b", k, digit_carry, edc[3:0]); end
      n_cmp++; if (carry !== edc[3]) begin n_err++; $display("FAIL rand carry[%0d]: got %b want %b", k, carry, edc[3]); end
      n_cmp++; if (at_term !== exp_at(mv, 10, 4, u)) begin n_err++; $display("FAIL rand at_term[%0d]: got %b want %b", k, at_term, exp_at(mv, 10, 4, u)); end
      tick();
      eq = to_q(mv, 10, 4);
      n_cmp++; if (Q !== eq[15:0]) begin n_err++; $display("FAIL rand Q[%0d]: got %h want %h", k, Q, eq[15:0]); end
    end
  endtask

  task automatic test_sweep_base6();
    logic [31:0] eq;
    int ncarry = 0;
    apply(0, 1, 1, 0, 16'h0000, 1);
    tick();
    n_cmp++; if (Q6 !== 8'h00) begin n_err++; $display("FAIL sweep_clr Q6: got %h want 00", Q6); end
    for (int k = 1; k <= 40; k++) begin
      apply(1, 1, 0, 0, 16'h0000, 1);
      if (carry6 === 1'b1) ncarry++;
      n_cmp++; if (carry6 !== (k == 36)) begin n_err++; $display("FAIL sweep carry6[%0d]: got %b want %b", k, carry6, (k == 36)); end
      tick();
      eq = to_q(mv6, 6, 2);
      n_cmp++; if (Q6 !== eq[7:0]) begin n_err++; $display("FAIL sweep Q6[%0d]: got %h want %h", k, Q6, eq[7:0]); end
      if (k == 10) begin
        n_cmp++; if (Q6 !== 8'h14) begin n_err++; $display("FAIL sweep Q6_10: got %h want 14", Q6); end
      end
    end
    n_cmp++; if (Q6 !== 8'h04) begin n_err++; $display("FAIL sweep Q6_40: got %h want 04", Q6); end
    n_cmp++; if (ncarry != 1) begin n_err++; $display("FAIL sweep carry_count: got %0d want 1", ncarry); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_saturate();
    test_priority_clamp();
    test_random();
    test_sweep_base6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
